// File: rtl/pwm_duty_decoder_pkg.sv
// Shared definitions for the PWM duty decoder and related PWM blocks:
// measurement FSM state encoding and the default counter width.
package pwm_duty_decoder_pkg;

    // Default width of the period and high-time counters.
    localparam int unsigned MEAS_LEN_DEFAULT = 8;

    // Measurement FSM states: waiting for a first edge, or timing a period.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_e;

endpackage : pwm_duty_decoder_pkg

// File: rtl/pwm_duty_decoder_sync.sv
// Synchronizer and rising-edge detector for an asynchronous PWM input.
// The edge flag is registered, so o_level is taken from the history flop to
// stay cycle-aligned with o_rise (both describe the same synchronized sample).
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;
    logic rise_r;

    // Two-flop synchronizer, history flop and registered rising-edge flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            s3_r   <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            s1_r   <= i_async;
            s2_r   <= s1_r;
            s3_r   <= s2_r;
            rise_r <= s2_r & ~s3_r;
        end
    end

    assign o_level = s3_r;
    assign o_rise  = rise_r;

endmodule : sync_edge_detect

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures the period (rise to rise) and high time of an
// asynchronous PWM input in clk cycles, and reports a stuck input (0% or
// 100% duty) when no rising edge arrives before the period counter saturates.
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int unsigned MEAS_LEN = MEAS_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pwm,
    output logic [MEAS_LEN-1:0] o_period,
    output logic [MEAS_LEN-1:0] o_high,
    output logic                o_valid,
    output logic                o_stuck,
    output logic                o_level
);

    localparam logic [MEAS_LEN-1:0] CNT_ZERO = {MEAS_LEN{1'b0}};
    localparam logic [MEAS_LEN-1:0] CNT_ONE  = {{(MEAS_LEN-1){1'b0}}, 1'b1};
    localparam logic [MEAS_LEN-1:0] CNT_MAX  = {MEAS_LEN{1'b1}};

    logic                level_sync_s;
    logic                rise_s;

    meas_state_e         state_r;
    meas_state_e         state_s;
    logic [MEAS_LEN-1:0] period_cnt_r;
    logic [MEAS_LEN-1:0] period_cnt_s;
    logic [MEAS_LEN-1:0] high_cnt_r;
    logic [MEAS_LEN-1:0] high_cnt_s;
    logic [MEAS_LEN-1:0] period_r;
    logic [MEAS_LEN-1:0] period_s;
    logic [MEAS_LEN-1:0] high_r;
    logic [MEAS_LEN-1:0] high_s;
    logic                valid_r;
    logic                valid_s;
    logic                stuck_r;
    logic                stuck_s;
    logic                level_r;
    logic                level_s;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_pwm),
        .o_level (level_sync_s),
        .o_rise  (rise_s)
    );

    // Next-state, counter and result logic; results change only on a strobe.
    always_comb begin
        state_s      = state_r;
        period_cnt_s = period_cnt_r;
        high_cnt_s   = high_cnt_r;
        period_s     = period_r;
        high_s       = high_r;
        valid_s      = 1'b0;
        stuck_s      = stuck_r;
        level_s      = level_r;
        case (state_r)
            ST_IDLE: begin
                // First rise only arms the measurement; nothing to report yet.
                if (rise_s) begin
                    state_s      = ST_MEASURE;
                    period_cnt_s = CNT_ONE;
                    high_cnt_s   = CNT_ONE;
                end else begin
                    state_s      = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // A rise closes the period and wins over a coincident timeout.
                if (rise_s) begin
                    period_s     = period_cnt_r;
                    high_s       = high_cnt_r;
                    stuck_s      = 1'b0;
                    valid_s      = 1'b1;
                    period_cnt_s = CNT_ONE;
                    high_cnt_s   = CNT_ONE;
                end else if (period_cnt_r == CNT_MAX) begin
                    period_s     = CNT_ZERO;
                    high_s       = CNT_ZERO;
                    stuck_s      = 1'b1;
                    level_s      = level_sync_s;
                    valid_s      = 1'b1;
                    period_cnt_s = CNT_ZERO;
                    high_cnt_s   = CNT_ZERO;
                    state_s      = ST_IDLE;
                end else begin
                    // High count only advances with the period count, so it
                    // can never exceed it.
                    period_cnt_s = period_cnt_r + CNT_ONE;
                    if (level_sync_s) begin
                        high_cnt_s = high_cnt_r + CNT_ONE;
                    end else begin
                        high_cnt_s = high_cnt_r;
                    end
                end
            end
            default: begin
                state_s      = ST_IDLE;
                period_cnt_s = CNT_ZERO;
                high_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= CNT_ZERO;
            high_cnt_r   <= CNT_ZERO;
            period_r     <= CNT_ZERO;
            high_r       <= CNT_ZERO;
            valid_r      <= 1'b0;
            stuck_r      <= 1'b0;
            level_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            period_cnt_r <= period_cnt_s;
            high_cnt_r   <= high_cnt_s;
            period_r     <= period_s;
            high_r       <= high_s;
            valid_r      <= valid_s;
            stuck_r      <= stuck_s;
            level_r      <= level_s;
        end
    end

    assign o_period = period_r;
    assign o_high   = high_r;
    assign o_valid  = valid_r;
    assign o_stuck  = stuck_r;
    assign o_level  = level_r;

endmodule : pwm_duty_decoder

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder. The stimulus process drives a
// PWM waveform cycle by cycle and runs a waveform-level reference model that
// pushes each expected strobe (values and arrival cycle) into a scoreboard
// queue; the monitor pops and compares on every o_valid, and checks that the
// outputs hold between strobes.
module tb_pwm_duty_decoder;

    localparam int MEAS_LEN = 8;
    localparam int CNT_MAX  = 255;
    localparam int LATENCY  = 4;  // drive cycle -> strobe cycle (3 after sampling edge)

    typedef struct {
        int   period;
        int   high;
        logic stuck;
        logic level;
        int   cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_pwm = 1'b0;
    logic [MEAS_LEN-1:0] o_period;
    logic [MEAS_LEN-1:0] o_high;
    logic                o_valid;
    logic                o_stuck;
    logic                o_level;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;

    // reference model state (stimulus process only)
    int   m_cnt = 0;
    int   m_high = 0;
    logic m_armed = 1'b0;
    logic m_prev = 1'b0;
    logic m_level = 1'b0;

    // last reported values (monitor only)
    logic [MEAS_LEN-1:0] last_p = '0;
    logic [MEAS_LEN-1:0] last_h = '0;
    logic                last_s = 1'b0;
    logic                last_l = 1'b0;

    pwm_duty_decoder #(.MEAS_LEN(MEAS_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_pwm    (i_pwm),
        .o_period (o_period),
        .o_high   (o_high),
        .o_valid  (o_valid),
        .o_stuck  (o_stuck),
        .o_level  (o_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One input cycle: drive, advance the reference model, wait for the edge.
    task automatic step(input logic b, input logic r);
        logic rise_m;
        i_pwm = b;
        rst   = r;
        rise_m = b & ~m_prev;
        m_prev = b;
        if (!m_armed) begin
            if (rise_m) begin
                m_armed = 1'b1;
                m_cnt   = 1;
                m_high  = 1;
            end
        end else if (rise_m) begin
            exp_q.push_back('{m_cnt, m_high, 1'b0, m_level, cyc + LATENCY});
            m_cnt  = 1;
            m_high = 1;
        end else if (m_cnt == CNT_MAX) begin
            m_level = b;
            exp_q.push_back('{0, 0, 1'b1, b, cyc + LATENCY});
            m_armed = 1'b0;
        end else begin
            m_cnt++;
            if (b) m_high++;
        end
        if (r) begin
            m_armed = 1'b0;
            m_prev  = 1'b0;
            m_level = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_bit(input logic b, input int n);
        repeat (n) step(b, 1'b0);
    endtask

    task automatic periods(input int p, input int h, input int n);
        repeat (n) begin
            run_bit(1'b1, h);
            run_bit(1'b0, p - h);
        end
    endtask

    // Stimulus: directed sequence of waveform phases.
    initial begin
        repeat (3) step(1'b0, 1'b1);        // reset
        run_bit(1'b0, 6);
        periods(16, 4, 6);                   // loopback-style steady train
        periods(16, 5, 1);                   // duty sweep
        periods(16, 6, 1);
        periods(16, 8, 1);
        periods(16, 3, 1);
        periods(16, 1, 1);
        periods(16, 15, 1);
        periods(16, 4, 1);
        run_bit(1'b0, 20);                   // isolated rise after long low
        run_bit(1'b1, 2);
        run_bit(1'b0, 10);
        periods(255, 10, 1);                 // rise exactly at counter max
        periods(16, 4, 2);
        run_bit(1'b0, 300);                  // stuck low: one timeout only
        periods(16, 4, 3);                   // re-arm, then measure
        run_bit(1'b1, 300);                  // stuck high
        run_bit(1'b0, 8);
        periods(16, 4, 3);
        periods(16, 4, 2);                   // reset halfway through a period
        run_bit(1'b1, 4);
        run_bit(1'b0, 4);
        step(1'b0, 1'b1);
        run_bit(1'b0, 7);
        periods(16, 4, 3);
        run_bit(1'b0, 10);
        done = 1'b1;
    end

    // Monitor: scoreboard compare on strobes, hold check otherwise, summary.
    always @(negedge clk) begin
        if (rst) begin
            last_p = '0;
            last_h = '0;
            last_s = 1'b0;
            last_l = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_strobe_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", int'(o_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_cycle", cyc, e.cyc);
                    check("period", int'(o_period), e.period);
                    check("high", int'(o_high), e.high);
                    check("stuck", int'(o_stuck), int'(e.stuck));
                    check("level", int'(o_level), int'(e.level));
                    last_p = e.period[MEAS_LEN-1:0];
                    last_h = e.high[MEAS_LEN-1:0];
                    last_s = e.stuck;
                    last_l = e.level;
                end
            end else begin
                check("hold_outputs", int'({o_period, o_high, o_stuck, o_level}),
                      int'({last_p, last_h, last_s, last_l}));
            end
        end
        if (done) begin
            check("pending_expectations", exp_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule : tb_pwm_duty_decoder
